mul_app_pipe: RTL and testbench

//  Pipelined, parametrised successor of the combinational approximate multiplier.
//  - Each operand is reduced to K bits: leading-one detect, keep the K-1 bits from the leading one down, force the LSB to 1.
//  - The two K-bit mantissas are multiplied, then the product is shifted back into place.
//  - Adds valid/ready flow control, a 3-stage pipeline and a runtime signed mode.
//  - Sits in the datapath between operand buffers and accumulator/MAC logic.

---
 rtl/mul_app_pipe_if.sv | 35 +++
 rtl/mul_app_pipe.sv | 114 +++++++++++
 tb/tb_mul_app_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_app_pipe_if.sv
// Operand/result handshake bundle for mul_app_pipe.
// Optional macro MUL_APP_EXACT_EN adds exact_w, the per-operand exact-multiply select.
interface mul_app_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid_w;
  logic               in_ready_w;
  logic               sign_w;
  logic [WIDTH-1:0]   n1_w;
  logic [WIDTH-1:0]   n2_w;
  logic               out_valid_w;
  logic               out_ready_w;
  logic [2*WIDTH-1:0] dout_w;
`ifdef MUL_APP_EXACT_EN
  logic               exact_w;

  modport master (
    output in_valid_w, sign_w, n1_w, n2_w, exact_w, out_ready_w,
    input  in_ready_w, out_valid_w, dout_w
  );
  modport slave (
    input  in_valid_w, sign_w, n1_w, n2_w, exact_w, out_ready_w,
    output in_ready_w, out_valid_w, dout_w
  );
`else
  modport master (
    output in_valid_w, sign_w, n1_w, n2_w, out_ready_w,
    input  in_ready_w, out_valid_w, dout_w
  );
  modport slave (
    input  in_valid_w, sign_w, n1_w, n2_w, out_ready_w,
    output in_ready_w, out_valid_w, dout_w
  );
`endif
endinterface

// File: rtl/mul_app_pipe.sv
// 3-stage approximate multiplier (leading-one truncation to K bits) with valid/ready flow control.
// Optional macro MUL_APP_EXACT_EN adds a runtime exact WIDTH x WIDTH multiply path.
module mul_app_pipe #(
  parameter int WIDTH = 16,
  parameter int K     = 6
) (
  input  logic          clk_w,
  input  logic          rst_w,
  mul_app_pipe_if.slave bus
);
  localparam int SHW = $clog2(2 * WIDTH);
`ifdef MUL_APP_EXACT_EN
  localparam int MW = WIDTH;
`else
  localparam int MW = K;
`endif

  typedef struct packed {
    logic [MW-1:0]  m;
    logic [SHW-1:0] s;
  } red_t;

  // Magnitude, then keep K bits from the leading one down with the LSB forced to 1.
  function automatic red_t reduce(input logic [WIDTH-1:0] a, input logic sg, input logic ex);
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] sh_mag;
    int               p;
    red_t             r;
    mag = (sg && a[WIDTH-1]) ? WIDTH'(-a) : a;
    p   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) p = i;
    end
    r.m    = MW'(mag);
    r.s    = '0;
    sh_mag = mag;
    if (!ex && p >= K) begin
      sh_mag = mag >> (p - K + 1);
      r.m    = MW'(sh_mag);
      r.m[0] = 1'b1;
      r.s    = SHW'(p - K + 1);
    end
    return r;
  endfunction

  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [MW-1:0]      m1_q, m1_d, m2_q, m2_d;
  logic [SHW-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic               neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*MW-1:0]    prod_q, prod_d;
  logic [SHW-1:0]     sh_q, sh_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic [2*WIDTH-1:0] r_w;
  logic               ex_w;
  logic               en;
  red_t               r1_w, r2_w;

`ifdef MUL_APP_EXACT_EN
  assign ex_w = bus.exact_w;
`else
  assign ex_w = 1'b0;
`endif

  // One global enable: the whole pipe stalls only when a result is waiting and not taken.
  assign en              = !v3_q || bus.out_ready_w;
  assign bus.in_ready_w  = en;
  assign bus.out_valid_w = v3_q;
  assign bus.dout_w      = dout_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch leaves a signal unassigned (no latches).
    v1_d   = v1_q;   v2_d = v2_q;     v3_d   = v3_q;
    m1_d   = m1_q;   m2_d = m2_q;     s1_d   = s1_q;   s2_d = s2_q;
    neg1_d = neg1_q; prod_d = prod_q; sh_d   = sh_q;   neg2_d = neg2_q;
    dout_d = dout_q;
    r1_w   = reduce(bus.n1_w, bus.sign_w, ex_w);
    r2_w   = reduce(bus.n2_w, bus.sign_w, ex_w);
    r_w    = (2*WIDTH)'(prod_q) << sh_q;
    if (en) begin
      v1_d = bus.in_valid_w;
      v2_d = v1_q;
      v3_d = v2_q;
      if (bus.in_valid_w) begin
        m1_d   = r1_w.m;
        m2_d   = r2_w.m;
        s1_d   = r1_w.s;
        s2_d   = r2_w.s;
        neg1_d = bus.sign_w && (bus.n1_w[WIDTH-1] ^ bus.n2_w[WIDTH-1])
                 && (bus.n1_w != '0) && (bus.n2_w != '0);
      end
      if (v1_q) begin
        prod_d = (2*MW)'(m1_q) * (2*MW)'(m2_q);
        sh_d   = s1_q + s2_q;
        neg2_d = neg1_q;
      end
      if (v2_q) dout_d = neg2_q ? -r_w : r_w;
    end
  end

  always_ff @(posedge clk_w) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst_w) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      m1_q <= '0;   m2_q <= '0;   s1_q <= '0;   s2_q <= '0;   neg1_q <= 1'b0;
      prod_q <= '0; sh_q <= '0;   neg2_q <= 1'b0;
      dout_q <= '0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      m1_q <= m1_d; m2_q <= m2_d; s1_q <= s1_d; s2_q <= s2_d; neg1_q <= neg1_d;
      prod_q <= prod_d; sh_q <= sh_d; neg2_q <= neg2_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_mul_app_pipe.sv
// Scoreboard bench for mul_app_pipe (WIDTH=16, K=6): directed vectors, back-pressure, reset flush, random.
// Exact-path vectors are added when MUL_APP_EXACT_EN is defined.
module tb_mul_app_pipe;
  localparam int WIDTH = 16;
  localparam int K     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_app_pipe_if #(.WIDTH(WIDTH)) bus ();
  mul_app_pipe #(.WIDTH(WIDTH), .K(K)) dut (.clk_w(clk), .rst_w(rst), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  bit          rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Approximation of one magnitude: keep K significant bits, round odd, scale back.
  function automatic longint approx(input longint x);
    longint p, s, q;
    if (x < (longint'(1) << K)) return x;
    p = 0;
    while ((longint'(1) << (p + 1)) <= x) p++;
    s = p - K + 1;
    q = x / (longint'(1) << s);
    if (q % 2 == 0) q = q + 1;
    return q * (longint'(1) << s);
  endfunction

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sg, input logic ex);
    longint ma, mb, r;
    bit     na, nb;
    na = sg && a[15];
    nb = sg && b[15];
    ma = na ? 65536 - longint'(a) : longint'(a);
    mb = nb ? 65536 - longint'(b) : longint'(b);
    r  = ex ? ma * mb : approx(ma) * approx(mb);
    if (ma == 0 || mb == 0) r = 0;
    return (na ^ nb) ? 32'(-r) : 32'(r);
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg,
                      input logic ex, input logic [31:0] exp);
    bit ok = 0;
    bus.n1_w = a; bus.n2_w = b; bus.sign_w = sg; bus.in_valid_w = 1'b1;
`ifdef MUL_APP_EXACT_EN
    bus.exact_w = ex;
`endif
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready_w) begin ok = 1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok) sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid_w = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    #1 check("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'($urandom_range(0, 63));
      2:       return $urandom_range(0, 1) ? 16'hFFFF : 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_w && bus.out_ready_w) begin
      if (sb.size() == 0) check("unexpected_output", bus.dout_w, 32'hxxxx_xxxx);
      else check("dout", bus.dout_w, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bpa[5], bpb[5];
    logic [31:0] bpe[5];
    int          cnt;
    bit          seen;
    bus.in_valid_w = 1'b0; bus.sign_w = 1'b0; bus.n1_w = '0; bus.n2_w = '0;
    bus.out_ready_w = 1'b1;
`ifdef MUL_APP_EXACT_EN
    bus.exact_w = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid_w), 32'd0);
    check("rst_dout", bus.dout_w, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready_w), 32'd1);

    send(16'd13, 16'd50, 1'b0, 1'b0, 32'd650);
    send(16'd1000, 16'd1000, 1'b0, 1'b0, 32'd1016064);
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hF810_0000);
    send(16'hFC18, 16'd1000, 1'b1, 1'b0, 32'hFFF0_7F00);
    send(16'h8000, 16'd1, 1'b1, 1'b0, 32'hFFFF_7C00);
    send(16'd0, 16'hFFFF, 1'b1, 1'b0, 32'd0);
`ifdef MUL_APP_EXACT_EN
    send(16'd1000, 16'd1000, 1'b0, 1'b1, 32'd1000000);
    send(16'd1000, 16'd1000, 1'b0, 1'b0, 32'd1016064);
`endif
    drain();

    // Back-pressure: five pairs against a stalled sink, then release.
    for (int i = 0; i < 5; i++) begin
      bpa[i] = rand_op(); bpb[i] = rand_op();
      bpe[i] = model(bpa[i], bpb[i], 1'b1, 1'b0);
    end
    bus.out_ready_w = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send(bpa[i], bpb[i], 1'b1, 1'b0, bpe[i]);
      begin
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge clk);
          seen = bus.out_valid_w;
        end
        check("bp_out_valid", 32'(seen), 32'd1);
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_dout", bus.dout_w, bpe[0]);
          check("bp_in_ready", 32'(bus.in_ready_w), 32'd0);
        end
        @(posedge clk); #1 bus.out_ready_w = 1'b1;
        cnt = 0;
        repeat (5) begin
          @(negedge clk);
          if (bus.out_valid_w) cnt++;
        end
        check("bp_consecutive", 32'(cnt), 32'd5);
      end
    join
    drain();

    // Reset with two results in flight: nothing stale may surface afterwards.
    send(16'd1000, 16'd1000, 1'b0, 1'b0, 32'd1016064);
    send(16'd13, 16'd50, 1'b0, 1'b0, 32'd650);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid_w), 32'd0);
    check("mid_rst_dout", bus.dout_w, 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready_w), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Random operands with a randomly stalling sink.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] a, b;
          logic        sg, ex;
          a  = rand_op(); b = rand_op();
          sg = 1'($urandom_range(0, 1));
`ifdef MUL_APP_EXACT_EN
          ex = 1'($urandom_range(0, 1));
`else
          ex = 1'b0;
`endif
          send(a, b, sg, ex, model(a, b, sg, ex));
        end
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        bus.out_ready_w = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready_w = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
